trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Machine-mode trap sequencer that decides when the CPU takes an interrupt, exception, or mret, and drives the control pulses the CSR array consumes (g_interrupt, g_exception, privilege). It stalls and drains the pipeline before an interrupt, orders simultaneous events by priority, and issues a handshaked PC redirect to fetch (mtvec on trap entry, mepc on mret). It sits between the EX stage, the CSR array and the fetch unit.

## Interface
Parameters: none.
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- ext_irq / timer_irq / soft_irq  in  1 each  level interrupt sources
- csr_meie / csr_mtie / csr_msie  in  1 each  per-source enables from mie
- csr_mstatus_mie  in  1  global M-mode interrupt enable
- csr_mtvec_ex  in  30  trap vector base, [31:2]
- csr_mepc_ex  in  30  return PC, [31:2]
- cpu_stat_ex  in  1  valid instruction in EX
- illegal_ops_ex / cmd_ecall_ex / cmd_mret_ex  in  1 each  EX decode flags
- pipe_idle  in  1  no in-flight memory/fetch transaction
- jmp_ack  in  1  fetch accepted redirect
- stall_req  out  1  hold fetch/decode
- flush_req  out  1  kill IF/ID instructions
- g_interrupt  out  1  interrupt-entry pulse to CSR
- g_exception  out  1  exception pulse to CSR
- g_interrupt_priv / g_current_priv  out  2 each  constant 2'b11
- trap_cause  out  5  latched cause code
- jmp_valid  out  1  redirect request
- jmp_adr  out  30  redirect target, [31:2]

## Operation
- pend_ext = ext_irq&csr_meie; pend_soft = soft_irq&csr_msie; pend_tim = timer_irq&csr_mtie; take = csr_mstatus_mie & any pend.
- Interrupt priority: ext (cause 11) > soft (3) > timer (7).
- Event priority in EX: exception (cpu_stat_ex&(illegal_ops_ex|cmd_ecall_ex)) > mret (cpu_stat_ex&cmd_mret_ex) > interrupt.
- FSM states IDLE, DRAIN, ENTRY, REDIRECT.
- IDLE: exception -> g_exception=1, flush_req=1 combinationally this cycle; latch jmp_adr=csr_mtvec_ex, trap_cause=2 (illegal) or 11 (ecall); -> REDIRECT. Else mret -> flush_req=1; jmp_adr=csr_mepc_ex; -> REDIRECT. Else take -> latch trap_cause by priority; -> DRAIN.
- DRAIN: stall_req=1. Exception in EX wins: behave as IDLE exception, -> REDIRECT, interrupt dropped. Else take low -> IDLE (abort, no pulse). Else pipe_idle -> ENTRY. trap_cause re-latched each cycle so a higher-priority source arriving in DRAIN wins.
- ENTRY (one cycle): g_interrupt=1, flush_req=1, stall_req=1; jmp_adr=interrupt target; -> REDIRECT.
- REDIRECT: jmp_valid=1, stall_req=1, jmp_adr stable; all events ignored; jmp_ack -> IDLE.
- Reset values: state IDLE; stall_req, flush_req, g_interrupt, g_exception, jmp_valid = 0; trap_cause=0; jmp_adr=0; priv outputs 2'b11.

## Timing
- Exception/mret seen in cycle N: flush_req (and g_exception) high in N; jmp_valid high from N+1 until the cycle jmp_ack is sampled high, inclusive; IDLE the following cycle.
- Interrupt pending in IDLE at N: stall_req high from N+1; pipe_idle sampled at M ≥ N+1; g_interrupt in M+1; jmp_valid from M+2. Minimum pending-to-jmp_valid latency: 3 cycles.
- g_interrupt and g_exception each last exactly one cycle per event and never overlap.
- jmp_ack ignored outside REDIRECT. jmp_ack in the first REDIRECT cycle: a one-cycle jmp_valid.
- rst_n low in any state forces IDLE and reset values immediately (asynchronous).

## Configuration
- TRAP_VECTORED_EN defined: interrupt target = csr_mtvec_ex + trap_cause (30-bit add, wraps modulo 2^30; byte address base + 4*cause). Exceptions use base.
- Undefined: all traps target csr_mtvec_ex directly.

## Test plan
- Reset: assert rst_n=0 mid-REDIRECT -> all outputs 0, g_current_priv=2'b11, state IDLE.
- Illegal op, mtvec byte 0x100: g_exception and flush pulse in same cycle; jmp_adr=30'h40; jmp_valid held 3 cycles until jmp_ack; trap_cause=2.
- timer_irq, mtie=1, mstatus_mie=1, pipe_idle low 4 cycles: stall_req 5+ cycles, one g_interrupt, trap_cause=7. Target byte 0x11C with TRAP_VECTORED_EN, 0x100 without.
- ext_irq and timer_irq asserted together: trap_cause=11. ext_irq alone then drops during DRAIN: return to IDLE, no g_interrupt.
- Interrupt in DRAIN, then ecall in EX: g_exception pulse, trap_cause=11 from ecall, g_interrupt never asserted.
- mret with mepc byte 0x200: flush_req pulse, jmp_adr=30'h80, no g_interrupt/g_exception.

Source files
------------

// File: rtl/trap_sequencer_if.sv
// Fetch redirect handshake between the trap sequencer and the fetch unit.
interface trap_sequencer_if;
    logic        jmp_valid;
    logic [29:0] jmp_adr;
    logic        jmp_ack;

    modport master (
        output jmp_valid,
        output jmp_adr,
        input  jmp_ack
    );

    modport slave (
        input  jmp_valid,
        input  jmp_adr,
        output jmp_ack
    );
endinterface

// File: rtl/trap_sequencer.sv
// M-mode trap sequencer: orders exceptions, mret and interrupts, drains the pipe.
// Define TRAP_VECTORED_EN for vectored interrupt targets (mtvec + cause).
module trap_sequencer (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ext_irq,
    input  logic                    timer_irq,
    input  logic                    soft_irq,
    input  logic                    csr_meie,
    input  logic                    csr_mtie,
    input  logic                    csr_msie,
    input  logic                    csr_mstatus_mie,
    input  logic [29:0]             csr_mtvec_ex,
    input  logic [29:0]             csr_mepc_ex,
    input  logic                    cpu_stat_ex,
    input  logic                    illegal_ops_ex,
    input  logic                    cmd_ecall_ex,
    input  logic                    cmd_mret_ex,
    input  logic                    pipe_idle,
    output logic                    stall_req,
    output logic                    flush_req,
    output logic                    g_interrupt,
    output logic                    g_exception,
    output logic [1:0]              g_interrupt_priv,
    output logic [1:0]              g_current_priv,
    output logic [4:0]              trap_cause,
    trap_sequencer_if.master        rd
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DRAIN,
        S_ENTRY,
        S_REDIRECT
    } state_e;

    state_e      state_q, state_d;
    logic [4:0]  trap_cause_q, trap_cause_d;
    logic [29:0] jmp_adr_q, jmp_adr_d;
    logic        jmp_valid;

    logic        pend_ext, pend_soft, pend_tim, take;
    logic        exc, mret;
    logic [4:0]  exc_cause, irq_cause;
    logic [29:0] irq_target;

    assign pend_ext  = ext_irq & csr_meie;
    assign pend_soft = soft_irq & csr_msie;
    assign pend_tim  = timer_irq & csr_mtie;
    assign take      = csr_mstatus_mie & (pend_ext | pend_soft | pend_tim);

    assign exc  = cpu_stat_ex & (illegal_ops_ex | cmd_ecall_ex);
    assign mret = cpu_stat_ex & cmd_mret_ex;

    assign exc_cause = illegal_ops_ex ? 5'd2 : 5'd11;
    assign irq_cause = pend_ext  ? 5'd11 :
                       pend_soft ? 5'd3  : 5'd7;

`ifdef TRAP_VECTORED_EN
    assign irq_target = csr_mtvec_ex + {25'd0, trap_cause_q};
`else
    assign irq_target = csr_mtvec_ex;
`endif

    always_comb begin
        state_d      = state_q;
        trap_cause_d = trap_cause_q;
        jmp_adr_d    = jmp_adr_q;
        stall_req    = 1'b0;
        flush_req    = 1'b0;
        g_interrupt  = 1'b0;
        g_exception  = 1'b0;
        jmp_valid    = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (exc) begin
                    g_exception  = 1'b1;
                    flush_req    = 1'b1;
                    jmp_adr_d    = csr_mtvec_ex;
                    trap_cause_d = exc_cause;
                    state_d      = S_REDIRECT;
                end else if (mret) begin
                    flush_req = 1'b1;
                    jmp_adr_d = csr_mepc_ex;
                    state_d   = S_REDIRECT;
                end else if (take) begin
                    trap_cause_d = irq_cause;
                    state_d      = S_DRAIN;
                end
            end
            S_DRAIN: begin
                stall_req = 1'b1;
                if (exc) begin
                    g_exception  = 1'b1;
                    flush_req    = 1'b1;
                    jmp_adr_d    = csr_mtvec_ex;
                    trap_cause_d = exc_cause;
                    state_d      = S_REDIRECT;
                end else if (!take) begin
                    state_d = S_IDLE;
                end else begin
                    // keep tracking the winner until the pipe is quiet
                    trap_cause_d = irq_cause;
                    if (pipe_idle) state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                g_interrupt = 1'b1;
                flush_req   = 1'b1;
                stall_req   = 1'b1;
                jmp_adr_d   = irq_target;
                state_d     = S_REDIRECT;
            end
            S_REDIRECT: begin
                jmp_valid = 1'b1;
                stall_req = 1'b1;
                if (rd.jmp_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        // IDLE decodes are combinational; hold them quiet during reset
        if (!rst_n) begin
            stall_req   = 1'b0;
            flush_req   = 1'b0;
            g_interrupt = 1'b0;
            g_exception = 1'b0;
            jmp_valid   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            trap_cause_q <= 5'd0;
            jmp_adr_q    <= 30'd0;
        end else begin
            state_q      <= state_d;
            trap_cause_q <= trap_cause_d;
            jmp_adr_q    <= jmp_adr_d;
        end
    end

    assign trap_cause       = trap_cause_q;
    assign rd.jmp_adr       = jmp_adr_q;
    assign rd.jmp_valid     = jmp_valid;
    assign g_interrupt_priv = 2'b11;
    assign g_current_priv   = 2'b11;

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: exceptions, mret, interrupts, drain, reset.
module tb_trap_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ext_irq, timer_irq, soft_irq;
    logic        csr_meie, csr_mtie, csr_msie, csr_mstatus_mie;
    logic [29:0] csr_mtvec_ex, csr_mepc_ex;
    logic        cpu_stat_ex, illegal_ops_ex, cmd_ecall_ex, cmd_mret_ex;
    logic        pipe_idle;
    logic        stall_req, flush_req, g_interrupt, g_exception;
    logic [1:0]  g_interrupt_priv, g_current_priv;
    logic [4:0]  trap_cause;

    int n_cmp = 0;
    int n_err = 0;
    int nst, ngi;

    trap_sequencer_if rd_if ();

    trap_sequencer dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .ext_irq          (ext_irq),
        .timer_irq        (timer_irq),
        .soft_irq         (soft_irq),
        .csr_meie         (csr_meie),
        .csr_mtie         (csr_mtie),
        .csr_msie         (csr_msie),
        .csr_mstatus_mie  (csr_mstatus_mie),
        .csr_mtvec_ex     (csr_mtvec_ex),
        .csr_mepc_ex      (csr_mepc_ex),
        .cpu_stat_ex      (cpu_stat_ex),
        .illegal_ops_ex   (illegal_ops_ex),
        .cmd_ecall_ex     (cmd_ecall_ex),
        .cmd_mret_ex      (cmd_mret_ex),
        .pipe_idle        (pipe_idle),
        .stall_req        (stall_req),
        .flush_req        (flush_req),
        .g_interrupt      (g_interrupt),
        .g_exception      (g_exception),
        .g_interrupt_priv (g_interrupt_priv),
        .g_current_priv   (g_current_priv),
        .trap_cause       (trap_cause),
        .rd               (rd_if.master)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic samp;
        @(negedge clk);
    endtask

    task automatic quiet;
        ext_irq        = 1'b0;
        timer_irq      = 1'b0;
        soft_irq       = 1'b0;
        cpu_stat_ex    = 1'b0;
        illegal_ops_ex = 1'b0;
        cmd_ecall_ex   = 1'b0;
        cmd_mret_ex    = 1'b0;
        rd_if.jmp_ack  = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [29:0] irq_adr;
`ifdef TRAP_VECTORED_EN
        irq_adr = 30'h47;
`else
        irq_adr = 30'h40;
`endif
        rst_n           = 1'b0;
        quiet();
        csr_meie        = 1'b0;
        csr_mtie        = 1'b0;
        csr_msie        = 1'b0;
        csr_mstatus_mie = 1'b0;
        csr_mtvec_ex    = 30'h40;
        csr_mepc_ex     = 30'h80;
        pipe_idle       = 1'b1;

        // reset state
        samp();
        chk("rst_stall", stall_req, 0);
        chk("rst_flush", flush_req, 0);
        chk("rst_jv", rd_if.jmp_valid, 0);
        chk("rst_cause", trap_cause, 0);
        chk("rst_adr", rd_if.jmp_adr, 0);
        chk("rst_cpriv", g_current_priv, 2'b11);
        chk("rst_ipriv", g_interrupt_priv, 2'b11);
        rst_n = 1'b1;
        tick();

        // illegal op
        cpu_stat_ex = 1'b1;
        illegal_ops_ex = 1'b1;
        samp();
        chk("ill_gexc", g_exception, 1);
        chk("ill_flush", flush_req, 1);
        chk("ill_gint", g_interrupt, 0);
        chk("ill_jv0", rd_if.jmp_valid, 0);
        tick();
        quiet();
        samp();
        chk("ill_jv1", rd_if.jmp_valid, 1);
        chk("ill_adr", rd_if.jmp_adr, 30'h40);
        chk("ill_cause", trap_cause, 2);
        chk("ill_gexc1", g_exception, 0);
        chk("ill_stall", stall_req, 1);
        tick();
        samp();
        chk("ill_jv2", rd_if.jmp_valid, 1);
        tick();
        rd_if.jmp_ack = 1'b1;
        samp();
        chk("ill_jv3", rd_if.jmp_valid, 1);
        tick();
        rd_if.jmp_ack = 1'b0;
        samp();
        chk("ill_done_jv", rd_if.jmp_valid, 0);
        chk("ill_done_st", stall_req, 0);
        tick();

        // ack outside REDIRECT is ignored
        rd_if.jmp_ack = 1'b1;
        samp();
        chk("ack_idle_jv", rd_if.jmp_valid, 0);
        tick();
        rd_if.jmp_ack = 1'b0;

        // exception outranks mret
        cpu_stat_ex = 1'b1;
        illegal_ops_ex = 1'b1;
        cmd_mret_ex = 1'b1;
        samp();
        chk("prio_gexc", g_exception, 1);
        tick();
        quiet();
        rd_if.jmp_ack = 1'b1;
        samp();
        chk("prio_adr", rd_if.jmp_adr, 30'h40);
        tick();
        rd_if.jmp_ack = 1'b0;

        // global mie masks interrupts
        csr_mtie = 1'b1;
        timer_irq = 1'b1;
        tick();
        samp();
        chk("mask_stall", stall_req, 0);
        tick();

        // timer interrupt with 4 busy cycles
        csr_mstatus_mie = 1'b1;
        pipe_idle = 1'b0;
        samp();
        chk("tim_idle_st", stall_req, 0);
        tick();
        nst = 0;
        ngi = 0;
        for (int i = 0; i < 5; i++) begin
            if (i == 4) pipe_idle = 1'b1;
            samp();
            nst += int'(stall_req);
            ngi += int'(g_interrupt);
            tick();
        end
        chk("tim_drain_st", nst, 5);
        chk("tim_drain_gi", ngi, 0);
        samp();
        chk("tim_gint", g_interrupt, 1);
        chk("tim_flush", flush_req, 1);
        chk("tim_cause", trap_cause, 7);
        chk("tim_gexc", g_exception, 0);
        tick();
        timer_irq = 1'b0;
        rd_if.jmp_ack = 1'b1;
        samp();
        chk("tim_jv", rd_if.jmp_valid, 1);
        chk("tim_adr", rd_if.jmp_adr, irq_adr);
        chk("tim_gint1", g_interrupt, 0);
        tick();
        rd_if.jmp_ack = 1'b0;
        samp();
        chk("tim_done_jv", rd_if.jmp_valid, 0);
        chk("tim_done_st", stall_req, 0);
        tick();

        // ext+timer together, ext drops, then timer drops -> abort
        csr_meie = 1'b1;
        ext_irq = 1'b1;
        timer_irq = 1'b1;
        pipe_idle = 1'b0;
        tick();
        samp();
        chk("both_cause", trap_cause, 11);
        chk("both_stall", stall_req, 1);
        ext_irq = 1'b0;
        tick();
        samp();
        chk("relatch_cause", trap_cause, 7);
        chk("relatch_gint", g_interrupt, 0);
        timer_irq = 1'b0;
        tick();
        samp();
        chk("abort_stall", stall_req, 0);
        chk("abort_gint", g_interrupt, 0);
        chk("abort_jv", rd_if.jmp_valid, 0);
        tick();

        // soft outranks timer
        csr_msie = 1'b1;
        soft_irq = 1'b1;
        timer_irq = 1'b1;
        tick();
        samp();
        chk("soft_cause", trap_cause, 3);
        soft_irq = 1'b0;
        timer_irq = 1'b0;
        tick();
        tick();

        // interrupt in DRAIN then ecall
        ext_irq = 1'b1;
        tick();
        cpu_stat_ex = 1'b1;
        cmd_ecall_ex = 1'b1;
        samp();
        chk("ecl_gexc", g_exception, 1);
        chk("ecl_flush", flush_req, 1);
        chk("ecl_gint", g_interrupt, 0);
        tick();
        quiet();
        samp();
        chk("ecl_jv", rd_if.jmp_valid, 1);
        chk("ecl_cause", trap_cause, 11);
        chk("ecl_adr", rd_if.jmp_adr, 30'h40);
        chk("ecl_gint1", g_interrupt, 0);
        chk("ecl_gexc1", g_exception, 0);
        rd_if.jmp_ack = 1'b1;
        tick();
        rd_if.jmp_ack = 1'b0;
        samp();
        chk("ecl_done_jv", rd_if.jmp_valid, 0);
        tick();

        // mret
        cpu_stat_ex = 1'b1;
        cmd_mret_ex = 1'b1;
        samp();
        chk("mret_flush", flush_req, 1);
        chk("mret_gexc", g_exception, 0);
        chk("mret_gint", g_interrupt, 0);
        tick();
        quiet();
        samp();
        chk("mret_jv", rd_if.jmp_valid, 1);
        chk("mret_adr", rd_if.jmp_adr, 30'h80);
        chk("mret_gexc1", g_exception, 0);
        rd_if.jmp_ack = 1'b1;
        tick();
        rd_if.jmp_ack = 1'b0;
        samp();
        chk("mret_done_jv", rd_if.jmp_valid, 0);
        tick();

        // reset mid-REDIRECT
        cpu_stat_ex = 1'b1;
        illegal_ops_ex = 1'b1;
        tick();
        quiet();
        samp();
        chk("mid_jv", rd_if.jmp_valid, 1);
        rst_n = 1'b0;
        #1;
        chk("mrst_jv", rd_if.jmp_valid, 0);
        chk("mrst_stall", stall_req, 0);
        chk("mrst_flush", flush_req, 0);
        chk("mrst_cause", trap_cause, 0);
        chk("mrst_adr", rd_if.jmp_adr, 0);
        chk("mrst_cpriv", g_current_priv, 2'b11);
        tick();
        rst_n = 1'b1;
        samp();
        chk("post_rst_jv", rd_if.jmp_valid, 0);
        chk("post_rst_st", stall_req, 0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
